obs_spawn_ctrl: RTL and testbench
=================================

// Module: obs_spawn_ctrl
// PURPOSE
//   Obstacle scheduler in front of the obstacle sprite ROM. Owns N_SLOTS obstacle slots (type + x),
//   spawns obstacles with pseudo-random type and gap, and scrolls them left on game ticks.
//   Per pixel it picks the slot covering (i_hpos,i_vpos) and drives the ROM address and type.
//   Sits between the game-state FSM (tick/run/clear) and the obstacle ROM/pixel mux.
// PARAMETERS
//   N_SLOTS         2     obstacle slots; slot 0 has the highest draw priority
//   X_SPAWN         640   x (sprite left edge) given to a newly spawned obstacle
//   Y_TOP           200   top row of the 16x16 obstacle band
//   MIN_GAP         24    minimum ticks between spawn attempts
//   SPEEDUP_SPAWNS  8     spawns per speed step (used only with OBS_SPEEDUP_EN)
// PORTS
//   clk            in   1      system clock
//   rst            in   1      asynchronous reset, active-high
//   i_tick         in   1      one-cycle game-tick strobe
//   i_run          in   1      1 = game running; 0 = hold positions
//   i_clear        in   1      synchronous clear of all slots (restart)
//   i_speed        in   4      pixels moved per tick
//   i_hpos         in   10     current pixel x
//   i_vpos         in   10     current pixel y
//   o_rom_counter  out  8      {rom_y,rom_x} to the obstacle ROM
//   o_obs_type     out  3      obstacle type to the obstacle ROM; 3'b000 = EMPTY
//   o_active       out  N_SLOTS  per-slot occupied flag
// BEHAVIOUR
//   - Reset (async): every slot type=000, x=0; state IDLE; gap counter=MIN_GAP; LFSR=16'hACE1;
//     all outputs 0.
//   - FSM: IDLE -(i_run)-> RUN; RUN -(!i_run)-> HOLD; HOLD -(i_run)-> RUN;
//     any state -(i_clear)-> IDLE with all slots emptied and gap counter=MIN_GAP.
//     i_clear beats i_tick/i_run in the same cycle.
//   - LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every clock in every state.
//   - Only RUN reacts to i_tick; IDLE and HOLD ignore it, and slots and gap counter keep their values.
//   - On a tick in RUN:
//     a) Each occupied slot with x >= eff_speed moves to x - eff_speed.
//        An occupied slot with x < eff_speed is freed (type=000).
//     b) If gap counter != 0, decrement it.
//        Else, if a free slot exists (freed in this tick included), spawn into the lowest-index free slot:
//        type=lfsr[2:0], x=X_SPAWN (no move this tick), gap counter=MIN_GAP+{lfsr[7:4],2'b00}.
//        If lfsr[2:0]==000, nothing is placed but the gap counter still reloads.
//        If no slot is free, the gap counter stays 0 and the spawn retries next tick.
//   - eff_speed = i_speed (4-bit). All x arithmetic is 10-bit unsigned; no wrap, because of the free rule.
//   - Pixel select (all states): slot s hits when type!=0, x <= i_hpos < x+16,
//     and Y_TOP <= i_vpos < Y_TOP+16. Use an 11-bit compare for x+16.
//     Lowest-index hit wins.
//     On a hit: o_rom_counter = {i_vpos-Y_TOP, i_hpos-x} (low 4 bits each) and o_obs_type = type.
//     On no hit: both are 0.
//   - Pixel select outputs are registered: 1-cycle latency from i_hpos/i_vpos.
//   - o_active[s] = (type[s]!=0), registered. It updates the cycle after a tick or clear.
// CONFIGURATION
//   OBS_SPEEDUP_EN defined:
//     - An internal 4-bit speed offset increments every SPEEDUP_SPAWNS successful spawns.
//       Spawns with type 000 do not count. The offset saturates at 15.
//     - eff_speed = min(i_speed + offset, 15).
//     - i_clear and rst zero the offset and the spawn count.
//   OBS_SPEEDUP_EN undefined: no offset logic; eff_speed = i_speed.
// TESTING
//   - Reset, hold i_run=0 with 50 ticks
//     -> o_active=0, o_obs_type=0, FSM stays IDLE, no spawn.
//   - Force LFSR type 011 and pulse i_run=1 plus ticks until gap=0
//     -> slot0 type=3, x=640; o_active=2'b01 one cycle later.
//   - Slot0 at x=100, i_speed=4, pixel (103,205)
//     -> next cycle o_rom_counter=8'h53, o_obs_type=slot0 type.
//   - Slot0 x=3, i_speed=4, tick -> slot0 freed (o_active[0]=0).
//     Slot1 x=20, i_speed=4, same tick -> slot1 x=16.
//   - Both slots occupied with gap=0: tick -> no spawn, gap stays 0.
//     Next tick that frees a slot -> spawn lands in that slot.
//   - Mid-run i_clear asserted together with i_tick
//     -> all slots empty, FSM IDLE, gap=MIN_GAP; positions unchanged by the tick.

Source files
------------

// File: rtl/obs_spawn_ctrl.sv
// rtl/obs_spawn_ctrl.sv - obstacle slot scheduler, spawner, scroller and per-pixel sprite select
// Optional feature macro: OBS_SPEEDUP_EN (speed offset that grows with successful spawns)
module obs_spawn_ctrl #(
   parameter int N_SLOTS        = 2,
   parameter int X_SPAWN        = 640,
   parameter int Y_TOP          = 200,
   parameter int MIN_GAP        = 24,
   parameter int SPEEDUP_SPAWNS = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_tick,
   input  logic               i_run,
   input  logic               i_clear,
   input  logic [3:0]         i_speed,
   input  logic [9:0]         i_hpos,
   input  logic [9:0]         i_vpos,
   output logic [7:0]         o_rom_counter,
   output logic [2:0]         o_obs_type,
   output logic [N_SLOTS-1:0] o_active
);

   localparam logic [9:0]  X_SPAWN_L = X_SPAWN[9:0];
   localparam logic [10:0] Y_TOP_L   = {1'b0, Y_TOP[9:0]};
   localparam logic [7:0]  MIN_GAP_L = MIN_GAP[7:0];
`ifdef OBS_SPEEDUP_EN
   localparam logic [7:0]  SPEEDUP_L = SPEEDUP_SPAWNS[7:0];
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         slot_type_q [N_SLOTS];
   logic [2:0]         slot_type_d [N_SLOTS];
   logic [9:0]         slot_x_q    [N_SLOTS];
   logic [9:0]         slot_x_d    [N_SLOTS];
   logic [7:0]         gap_q, gap_d;
   logic [15:0]        lfsr_q, lfsr_d;
   logic [7:0]         rom_counter_q, rom_counter_d;
   logic [2:0]         obs_type_q, obs_type_d;
   logic [N_SLOTS-1:0] active_q, active_d;
   logic [3:0]         eff_speed;
   logic               free_found;
   logic               pix_hit;
   logic               v_band;
`ifdef OBS_SPEEDUP_EN
   logic [3:0]         offset_q, offset_d;
   logic [7:0]         spawn_cnt_q, spawn_cnt_d;
   logic [4:0]         speed_sum;
`endif

   // effective scroll speed: raw input, optionally boosted by the saturating offset
`ifdef OBS_SPEEDUP_EN
   always_comb begin
      speed_sum = {1'b0, i_speed} + {1'b0, offset_q};
      eff_speed = speed_sum[4] ? 4'hF : speed_sum[3:0];
   end
`else
   always_comb begin
      eff_speed = i_speed;
   end
`endif

   // next-state: FSM, LFSR, slot scroll/free, gap countdown and spawn
   always_comb begin
      state_d    = state_q;
      gap_d      = gap_q;
      lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      free_found = 1'b0;
      for (int s = 0; s < N_SLOTS; s++) begin
         slot_type_d[s] = slot_type_q[s];
         slot_x_d[s]    = slot_x_q[s];
      end
`ifdef OBS_SPEEDUP_EN
      offset_d    = offset_q;
      spawn_cnt_d = spawn_cnt_q;
`endif
      if (i_clear) begin
         state_d = ST_IDLE;
         gap_d   = MIN_GAP_L;
         for (int s = 0; s < N_SLOTS; s++) begin
            slot_type_d[s] = 3'd0;
            slot_x_d[s]    = 10'd0;
         end
`ifdef OBS_SPEEDUP_EN
         offset_d    = 4'd0;
         spawn_cnt_d = 8'd0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: if (i_run)  state_d = ST_RUN;
            ST_RUN:  if (!i_run) state_d = ST_HOLD;
            ST_HOLD: if (i_run)  state_d = ST_RUN;
            default: state_d = ST_IDLE;
         endcase
         if (state_q == ST_RUN && i_tick) begin
            // scroll first so that a slot freed by this tick can take the spawn
            for (int s = 0; s < N_SLOTS; s++) begin
               if (slot_type_q[s] != 3'd0) begin
                  if (slot_x_q[s] >= {6'd0, eff_speed}) begin
                     slot_x_d[s] = slot_x_q[s] - {6'd0, eff_speed};
                  end else begin
                     slot_type_d[s] = 3'd0;
                  end
               end
            end
            if (gap_q != 8'd0) begin
               gap_d = gap_q - 8'd1;
            end else begin
               for (int s = 0; s < N_SLOTS; s++) begin
                  if (!free_found && slot_type_d[s] == 3'd0) begin
                     free_found = 1'b1;
                     if (lfsr_q[2:0] != 3'd0) begin
                        slot_type_d[s] = lfsr_q[2:0];
                        slot_x_d[s]    = X_SPAWN_L;
                     end
                  end
               end
               // gap stays 0 when every slot is busy, so the spawn retries next tick
               if (free_found) begin
                  gap_d = MIN_GAP_L + {2'b00, lfsr_q[7:4], 2'b00};
               end
`ifdef OBS_SPEEDUP_EN
               if (free_found && lfsr_q[2:0] != 3'd0) begin
                  if (spawn_cnt_q + 8'd1 >= SPEEDUP_L) begin
                     spawn_cnt_d = 8'd0;
                     offset_d    = (offset_q == 4'hF) ? 4'hF : offset_q + 4'd1;
                  end else begin
                     spawn_cnt_d = spawn_cnt_q + 8'd1;
                  end
               end
`endif
            end
         end
      end
      for (int s = 0; s < N_SLOTS; s++) begin
         active_d[s] = (slot_type_d[s] != 3'd0);
      end
   end

   // pixel select: lowest-index slot covering the current pixel drives the ROM
   always_comb begin
      rom_counter_d = 8'd0;
      obs_type_d    = 3'd0;
      pix_hit       = 1'b0;
      v_band        = ({1'b0, i_vpos} >= Y_TOP_L) && ({1'b0, i_vpos} < Y_TOP_L + 11'd16);
      for (int s = 0; s < N_SLOTS; s++) begin
         if (!pix_hit && v_band && slot_type_q[s] != 3'd0 &&
             {1'b0, i_hpos} >= {1'b0, slot_x_q[s]} &&
             {1'b0, i_hpos} <  {1'b0, slot_x_q[s]} + 11'd16) begin
            pix_hit       = 1'b1;
            obs_type_d    = slot_type_q[s];
            rom_counter_d = {i_vpos[3:0] - Y_TOP_L[3:0], i_hpos[3:0] - slot_x_q[s][3:0]};
         end
      end
   end

   // state and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         gap_q         <= MIN_GAP_L;
         lfsr_q        <= 16'hACE1;
         rom_counter_q <= 8'd0;
         obs_type_q    <= 3'd0;
         active_q      <= '0;
         for (int s = 0; s < N_SLOTS; s++) begin
            slot_type_q[s] <= 3'd0;
            slot_x_q[s]    <= 10'd0;
         end
`ifdef OBS_SPEEDUP_EN
         offset_q    <= 4'd0;
         spawn_cnt_q <= 8'd0;
`endif
      end else begin
         state_q       <= state_d;
         gap_q         <= gap_d;
         lfsr_q        <= lfsr_d;
         rom_counter_q <= rom_counter_d;
         obs_type_q    <= obs_type_d;
         active_q      <= active_d;
         for (int s = 0; s < N_SLOTS; s++) begin
            slot_type_q[s] <= slot_type_d[s];
            slot_x_q[s]    <= slot_x_d[s];
         end
`ifdef OBS_SPEEDUP_EN
         offset_q    <= offset_d;
         spawn_cnt_q <= spawn_cnt_d;
`endif
      end
   end

   assign o_rom_counter = rom_counter_q;
   assign o_obs_type    = obs_type_q;
   assign o_active      = active_q;

endmodule

// File: tb/tb_obs_spawn_ctrl.sv
// tb/tb_obs_spawn_ctrl.sv - randomized bench for obs_spawn_ctrl against a slot-list reference model
`timescale 1ns/1ps
module tb_obs_spawn_ctrl;

   localparam int N_SLOTS        = 2;
   localparam int X_SPAWN        = 640;
   localparam int Y_TOP          = 200;
   localparam int MIN_GAP        = 24;
   localparam int SPEEDUP_SPAWNS = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic               i_tick;
   logic               i_run;
   logic               i_clear;
   logic [3:0]         i_speed;
   logic [9:0]         i_hpos;
   logic [9:0]         i_vpos;
   logic [7:0]         o_rom_counter;
   logic [2:0]         o_obs_type;
   logic [N_SLOTS-1:0] o_active;

   obs_spawn_ctrl #(
      .N_SLOTS(N_SLOTS), .X_SPAWN(X_SPAWN), .Y_TOP(Y_TOP),
      .MIN_GAP(MIN_GAP), .SPEEDUP_SPAWNS(SPEEDUP_SPAWNS)
   ) dut (
      .clk(clk), .rst(rst), .i_tick(i_tick), .i_run(i_run), .i_clear(i_clear),
      .i_speed(i_speed), .i_hpos(i_hpos), .i_vpos(i_vpos),
      .o_rom_counter(o_rom_counter), .o_obs_type(o_obs_type), .o_active(o_active)
   );

   always #5 clk = ~clk;

   int n_vec     = 0;
   int n_miscmp  = 0;
   int cyc       = 0;

   // reference model: plain per-slot lists and a named mode
   int    m_type [N_SLOTS];
   int    m_x    [N_SLOTS];
   int    m_gap;
   int    m_lfsr;
   int    m_off;
   int    m_cnt;
   string m_mode;
   int    exp_rom;
   int    exp_type;
   int    exp_active;

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_miscmp++;
         $display("FAIL %s @cycle %0d: got %0d, want %0d", tag, cyc, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < N_SLOTS; s++) begin
         m_type[s] = 0;
         m_x[s]    = 0;
      end
      m_gap = MIN_GAP; m_lfsr = 16'hACE1; m_off = 0; m_cnt = 0; m_mode = "IDLE";
      exp_rom = 0; exp_type = 0; exp_active = 0;
   endtask

   task automatic model_step(input bit tick, input bit run, input bit clear,
                             input int speed, input int h, input int v);
      int  ht, hr, eff, free_s, fb;
      bit  found;
      ht = 0; hr = 0; found = 0;
      for (int s = 0; s < N_SLOTS; s++) begin
         if (!found && m_type[s] != 0 && h >= m_x[s] && h < m_x[s] + 16 &&
             v >= Y_TOP && v < Y_TOP + 16) begin
            found = 1;
            ht    = m_type[s];
            hr    = (v - Y_TOP) * 16 + (h - m_x[s]);
         end
      end
      if (clear) begin
         for (int s = 0; s < N_SLOTS; s++) m_type[s] = 0;
         m_gap = MIN_GAP; m_mode = "IDLE"; m_off = 0; m_cnt = 0;
      end else begin
         if (m_mode == "RUN" && tick) begin
            eff = speed + m_off;
            if (eff > 15) eff = 15;
            for (int s = 0; s < N_SLOTS; s++) begin
               if (m_type[s] != 0) begin
                  if (m_x[s] >= eff) m_x[s] = m_x[s] - eff;
                  else               m_type[s] = 0;
               end
            end
            if (m_gap > 0) begin
               m_gap = m_gap - 1;
            end else begin
               free_s = -1;
               for (int s = N_SLOTS - 1; s >= 0; s--) if (m_type[s] == 0) free_s = s;
               if (free_s >= 0) begin
                  if ((m_lfsr % 8) != 0) begin
                     m_type[free_s] = m_lfsr % 8;
                     m_x[free_s]    = X_SPAWN;
`ifdef OBS_SPEEDUP_EN
                     m_cnt = m_cnt + 1;
                     if (m_cnt == SPEEDUP_SPAWNS) begin
                        m_cnt = 0;
                        if (m_off < 15) m_off = m_off + 1;
                     end
`endif
                  end
                  m_gap = MIN_GAP + ((m_lfsr / 16) % 16) * 4;
               end
            end
         end
         if      (m_mode == "IDLE" && run)  m_mode = "RUN";
         else if (m_mode == "RUN"  && !run) m_mode = "HOLD";
         else if (m_mode == "HOLD" && run)  m_mode = "RUN";
      end
      fb     = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
      m_lfsr = ((m_lfsr * 2) + fb) % 65536;
      exp_rom    = hr;
      exp_type   = ht;
      exp_active = 0;
      for (int s = 0; s < N_SLOTS; s++) if (m_type[s] != 0) exp_active += (1 << s);
   endtask

   // one clock: drive at the falling edge, let the rising edge consume it, compare at the next fall
   task automatic cycle_step(input bit tick, input bit run, input bit clear,
                             input int speed, input int h, input int v);
      i_tick  = tick;
      i_run   = run;
      i_clear = clear;
      i_speed = speed[3:0];
      i_hpos  = h[9:0];
      i_vpos  = v[9:0];
      model_step(tick, run, clear, speed, h, v);
      @(negedge clk);
      cyc++;
      check("rom_counter", int'(o_rom_counter), exp_rom);
      check("obs_type",    int'(o_obs_type),    exp_type);
      check("active",      int'(o_active),      exp_active);
   endtask

   // pixel near an occupied slot most of the time so that hits and edges are exercised
   task automatic pick_pixel(output int h, output int v);
      int s;
      s = $urandom_range(N_SLOTS - 1);
      if ($urandom_range(3) != 0 && m_type[s] != 0) begin
         h = (m_x[s] + $urandom_range(23) + 1020) % 1024;
         v = Y_TOP - 2 + $urandom_range(19);
      end else begin
         h = $urandom_range(1023);
         v = $urandom_range(1023);
      end
   endtask

   initial begin
      int h, v;
      bit tk, rn, cl;
      rst = 1'b1; i_tick = 1'b0; i_run = 1'b0; i_clear = 1'b0;
      i_speed = 4'd0; i_hpos = 10'd0; i_vpos = 10'd0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_rom_counter", int'(o_rom_counter), 0);
      check("rst_obs_type",    int'(o_obs_type),    0);
      check("rst_active",      int'(o_active),      0);
      rst = 1'b0;

      // idle with ticks and run low: nothing may spawn
      for (int c = 0; c < 100; c++) begin
         pick_pixel(h, v);
         cycle_step(c % 2 == 0, 1'b0, 1'b0, $urandom_range(15), h, v);
      end

      // main randomized run, with a forced clear+tick while running
      for (int c = 0; c < 4000; c++) begin
         pick_pixel(h, v);
         tk = ($urandom_range(2) != 0);
         rn = ($urandom_range(99) < 93);
         cl = ($urandom_range(599) == 0);
         if (c == 1500 || c == 3000) begin
            tk = 1'b1; rn = 1'b1; cl = 1'b1;
         end
         cycle_step(tk, rn, cl, ($urandom_range(9) == 0) ? 0 : $urandom_range(15), h, v);
      end

      // hold: ticks must not move anything
      for (int c = 0; c < 60; c++) begin
         pick_pixel(h, v);
         cycle_step(1'b1, 1'b0, 1'b0, $urandom_range(15), h, v);
      end

      // resume, then a final clear
      for (int c = 0; c < 300; c++) begin
         pick_pixel(h, v);
         cycle_step($urandom_range(1) == 1, 1'b1, c == 299, $urandom_range(15), h, v);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
